mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage with a 2-entry skid buffer, valid/ready handshakes on both sides, cache-hit gating and synchronous flush. Sits between the data-memory/cache stage and register-file writeback. Replaces the single-register MEM/WB latch: nothing is lost when writeback back-pressures, and the writeback data mux is resolved inside the stage.

---
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 2-entry skid buffer with valid/ready handshakes, cache-hit gating,
// synchronous flush and an internal writeback mux. Optional stall counter via MEM_WB_STALL_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_W-1:0]  write_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   head, head_next;
    logic   tail;
    logic   push, pop;

    logic [DATA_W-1:0] rd_slot  [2];
    logic [DATA_W-1:0] alu_slot [2];
    logic [REG_W-1:0]  wr_slot  [2];
    logic              rw_slot  [2];
    logic              m2r_slot [2];

    // in_ready is forced low during reset so MEM never sees a phantom accept.
    assign in_ready  = rst_n && hit && (state != FULL) && !flush;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign tail      = (state == EMPTY) ? head : ~head;

    always_comb begin
        state_next = state;
        head_next  = head;
        if (flush) begin
            state_next = EMPTY;
            head_next  = 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) state_next = ONE;
                end
                ONE: begin
                    if (push && !pop) begin
                        state_next = FULL;
                    end else if (pop) begin
                        state_next = push ? ONE : EMPTY;
                        head_next  = ~head;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        head_next  = ~head;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    head_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= 1'b0;
        end else begin
            state <= state_next;
            head  <= head_next;
        end
    end

    // Payload slots are left untouched by flush; only reset clears them.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rd_slot[i]  <= '0;
                alu_slot[i] <= '0;
                wr_slot[i]  <= '0;
                rw_slot[i]  <= 1'b0;
                m2r_slot[i] <= 1'b0;
            end
        end else if (push) begin
            rd_slot[tail]  <= read_data;
            alu_slot[tail] <= alu_result;
            wr_slot[tail]  <= write_reg;
            rw_slot[tail]  <= reg_write;
            m2r_slot[tail] <= mem_to_reg;
        end
    end

    assign read_data_out  = rd_slot[head];
    assign alu_result_out = alu_slot[head];
    assign write_reg_out  = wr_slot[head];
    assign reg_write_out  = rw_slot[head] && out_valid;
    assign mem_to_reg_out = m2r_slot[head];
    assign wb_data        = m2r_slot[head] ? rd_slot[head] : alu_slot[head];

`ifdef MEM_WB_STALL_CNT_EN
    // Counts cycles where MEM offers an entry but the cache missed; flush leaves it alone.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (in_valid && !hit && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of the 2-entry buffer.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct {
        logic [DW-1:0] rd;
        logic [DW-1:0] alu;
        logic [RW-1:0] wr;
        logic          rw;
        logic          m2r;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hit, flush, in_valid, out_ready, reg_write, mem_to_reg;
    logic          in_ready, out_valid, reg_write_out, mem_to_reg_out;
    logic [DW-1:0] read_data, alu_result, read_data_out, alu_result_out, wb_data;
    logic [RW-1:0] write_reg, write_reg_out;
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int     compared = 0;
    int     mismatched = 0;
    entry_t q[$];
    int     stall_model = 0;
    logic   exp_ready, obs_ready;

    mem_wb_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .write_reg_out(write_reg_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .wb_data(wb_data)
`ifdef MEM_WB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                                  input logic [RW-1:0] wr, input logic rw, input logic m2r);
        entry_t e;
        e.rd = rd; e.alu = alu; e.wr = wr; e.rw = rw; e.m2r = m2r;
        return e;
    endfunction

    function automatic entry_t rand_entry();
        return mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    function automatic logic [DW-1:0] exp_wb();
        return q[0].m2r ? q[0].rd : q[0].alu;
    endfunction

    // Called at posedge+1; drives one cycle of inputs, advances the model at the falling edge.
    task automatic step(input logic iv, input logic h, input logic fl, input logic ordy, input entry_t e);
        logic do_push, do_pop;
        in_valid = iv; hit = h; flush = fl; out_ready = ordy;
        read_data = e.rd; alu_result = e.alu; write_reg = e.wr;
        reg_write = e.rw; mem_to_reg = e.m2r;
        #1;
        obs_ready = in_ready;
        exp_ready = h && !fl && (q.size() < 2);
        @(negedge clk);
        do_push = iv && exp_ready;
        do_pop  = (q.size() > 0) && ordy;
        if (iv && !h && stall_model < 65535) stall_model++;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b1, 1'b0, ordy, mk('0, '0, '0, 1'b0, 1'b0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        compared++; if (wb_data !== '0) begin mismatched++; $display("[TB] FAIL reset_wb_data got %h want 0", wb_data); end
        compared++; if (write_reg_out !== '0 || reg_write_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_reg got %0d/%b want 0/0", write_reg_out, reg_write_out); end
        q.delete();
        stall_model = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, mk($urandom, DW'(i), 5'(i), 1'b1, 1'b0));
            compared++; if (obs_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_ready%0d got %b want 1", i, obs_ready); end
            compared++; if (out_valid !== 1'b1 || wb_data !== DW'(i)) begin mismatched++; $display("[TB] FAIL stream_wb%0d got %b/%h want 1/%h", i, out_valid, wb_data, i); end
        end
        idle(1'b1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        entry_t a, b;
        a = mk($urandom, 32'hA, 5'd1, 1'b1, 1'b0);
        b = mk($urandom, 32'hB, 5'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 1'b1, 1'b0, 1'b0, b);
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_entry());
        compared++; if (obs_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_full_ready got %b want 0", obs_ready); end
        compared++; if (wb_data !== 32'hA || out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_head_a got %b/%h want 1/a", out_valid, wb_data); end
        idle(1'b1);
        compared++; if (wb_data !== 32'hB || out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_head_b got %b/%h want 1/b", out_valid, wb_data); end
        idle(1'b1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_cache_miss();
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_entry());
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_entry());
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, rand_entry());
            compared++; if (obs_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_ready%0d got %b want 0", i, obs_ready); end
        end
        compared++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_drain got %b/%b want 0/0", out_valid, reg_write_out); end
`ifdef MEM_WB_STALL_CNT_EN
        compared++; if (stall_cnt !== 16'(stall_model)) begin mismatched++; $display("[TB] FAIL miss_stall_cnt got %0d want %0d", stall_cnt, stall_model); end
`endif
    endtask

    task automatic test_flush();
        step(1'b1, 1'b1, 1'b0, 1'b0, mk($urandom, $urandom, 5'd3, 1'b1, 1'b0));
        step(1'b1, 1'b1, 1'b1, 1'b1, mk($urandom, $urandom, 5'd4, 1'b1, 1'b0));
        compared++; if (obs_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_ready got %b want 0", obs_ready); end
        compared++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_empty got %b/%b want 0/0", out_valid, reg_write_out); end
        idle(1'b1);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stays_empty got %b want 0", out_valid); end
    endtask

    task automatic test_load_mux();
        step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'hDEADBEEF, 32'h10, 5'd9, 1'b1, 1'b1));
        compared++; if (wb_data !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL load_wb got %h want deadbeef", wb_data); end
        compared++; if (write_reg_out !== 5'd9 || reg_write_out !== 1'b1) begin mismatched++; $display("[TB] FAIL load_reg got %0d/%b want 9/1", write_reg_out, reg_write_out); end
        compared++; if (alu_result_out !== 32'h10 || mem_to_reg_out !== 1'b1) begin mismatched++; $display("[TB] FAIL load_fields got %h/%b want 10/1", alu_result_out, mem_to_reg_out); end
        idle(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6), rand_entry());
            compared++; if (obs_ready !== exp_ready) begin mismatched++; $display("[TB] FAIL rand_ready@%0d got %b want %b", i, obs_ready, exp_ready); end
            compared++; if (out_valid !== (q.size() != 0)) begin mismatched++; $display("[TB] FAIL rand_valid@%0d got %b want %b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                compared++; if (wb_data !== exp_wb()) begin mismatched++; $display("[TB] FAIL rand_wb@%0d got %h want %h", i, wb_data, exp_wb()); end
                compared++;
                if (read_data_out !== q[0].rd || alu_result_out !== q[0].alu || write_reg_out !== q[0].wr
                    || reg_write_out !== q[0].rw || mem_to_reg_out !== q[0].m2r) begin
                    mismatched++;
                    $display("[TB] FAIL rand_fields@%0d got %h/%h/%0d/%b/%b want %h/%h/%0d/%b/%b", i,
                             read_data_out, alu_result_out, write_reg_out, reg_write_out, mem_to_reg_out,
                             q[0].rd, q[0].alu, q[0].wr, q[0].rw, q[0].m2r);
                end
            end else begin
                compared++; if (reg_write_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rand_bubble_rw@%0d got %b want 0", i, reg_write_out); end
            end
`ifdef MEM_WB_STALL_CNT_EN
            compared++; if (stall_cnt !== 16'(stall_model)) begin mismatched++; $display("[TB] FAIL rand_stall@%0d got %0d want %0d", i, stall_cnt, stall_model); end
`endif
        end
    endtask

    task automatic test_async_reset();
        entry_t e;
        step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h1234, 32'h5678, 5'd7, 1'b1, 1'b1));
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_entry());
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_hs got %b/%b want 0/0", out_valid, in_ready); end
        compared++;
        if (read_data_out !== '0 || alu_result_out !== '0 || write_reg_out !== '0 || reg_write_out !== 1'b0
            || mem_to_reg_out !== 1'b0 || wb_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL areset_data got %h/%h/%0d/%b/%b/%h want all 0", read_data_out, alu_result_out,
                     write_reg_out, reg_write_out, mem_to_reg_out, wb_data);
        end
`ifdef MEM_WB_STALL_CNT_EN
        compared++; if (stall_cnt !== 16'h0) begin mismatched++; $display("[TB] FAIL areset_stall got %0d want 0", stall_cnt); end
`endif
        q.delete();
        stall_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = mk($urandom, 32'h77, 5'd5, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, e);
        compared++; if (out_valid !== 1'b1 || wb_data !== 32'h77) begin mismatched++; $display("[TB] FAIL areset_first_push got %b/%h want 1/77", out_valid, wb_data); end
    endtask

    initial begin
        hit = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        read_data = '0; alu_result = '0; write_reg = '0; reg_write = 1'b0; mem_to_reg = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_back_pressure();
        test_cache_miss();
        test_flush();
        test_load_mux();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
